execute_alu_dispatcher: RTL
===========================

Name: execute_alu_dispatcher

Overview:
- Sits between the issue stage and ALU_NUM parallel ALU execute units, each fed by its own issue-to-ALU FIFO.
- Accepts at most one issue_execute_pack_t per cycle and routes it round-robin to an ALU FIFO with free space.
- Tracks each FIFO's occupancy with credit counters, decremented by the execute unit's pop strobe.
- A commit flush aborts in-flight dispatch and clears all credits.

Parameters:
- ALU_NUM, 2, number of ALU execute units and FIFOs (2..8).
- FIFO_DEPTH, 4, entries per issue-to-ALU FIFO (power of two not required, 1..16).
- CNT_W, $clog2(FIFO_DEPTH+1), credit counter width (derived).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low (rst==0 resets)
- issue_data  input  issue_execute_pack_t  instruction offered by issue
- issue_valid  input  1  issue_data valid
- issue_ready  output  1  dispatcher accepts issue_data this cycle
- alu_fifo_data_in  output  issue_execute_pack_t  registered packet, broadcast to all FIFOs
- alu_fifo_push  output  ALU_NUM  one-hot push strobe, registered
- alu_fifo_pop  input  ALU_NUM  per-unit pop strobe from each execute unit
- alu_fifo_occupancy  output  ALU_NUM*CNT_W  current credit count per FIFO
- commit_feedback_pack  input  commit_feedback_pack_t  flush when enable && flush
- credit_error  output  1  sticky: pop seen with occupancy 0, or push to a full FIFO

Behaviour:
- Reset (rst==0 at clk edge): alu_fifo_push=0, alu_fifo_data_in=0, all occupancy=0, rr_ptr=0, credit_error=0.
- flush = commit_feedback_pack.enable && commit_feedback_pack.flush (combinational).
- Selection (combinational):
  - Scan i = rr_ptr, rr_ptr+1, ... mod ALU_NUM; sel = first i with occ[i] < FIFO_DEPTH.
  - any_free = sel exists.
  - Same-cycle pops are not counted toward free space (conservative).
- issue_ready = any_free && !flush.
- accept = issue_valid && issue_ready.
- Dispatch latency is 1 cycle. On accept, next cycle drives alu_fifo_push = one-hot(sel) and alu_fifo_data_in = issue_data. Otherwise push=0 and data holds its last value.
- rr_ptr: on accept becomes (sel+1) mod ALU_NUM; otherwise holds. Held across flush.
- Credit update per i, each cycle:
  - occ[i] += (accept && sel==i), the credit is consumed at accept time, not at the registered push.
  - occ[i] -= alu_fifo_pop[i].
  - Accept and pop on the same i in the same cycle: occ unchanged.
  - Pop with occ[i]==0 (and no accept on i): occ stays 0, credit_error set.
- Flush cycle:
  - issue_ready=0, so nothing is accepted.
  - Next cycle: alu_fifo_push=0, which kills any registered push pending from the previous cycle's accept. All occ=0.
  - The FIFOs clear themselves on the same flush, so pops during the flush cycle are ignored.
- Packets are forwarded unmodified. Invalid or exception packets are dispatched like any other.
- credit_error clears only on reset.
- Reset mid-dispatch: the pending push is dropped and the next cycle's outputs are at reset values.

Decomposition:
- Shared package (common.svh):
  - ALU_NUM and FIFO_DEPTH defaults as `ALU_UNIT_NUM / `ALU_FIFO_DEPTH in config.svh.
  - No new typedefs; reuses issue_execute_pack_t and commit_feedback_pack_t.
- Sub-module rr_free_select: a parameterised round-robin first-free picker.
  - Inputs: start pointer, free vector.
  - Outputs: one-hot sel, index, any.
  - Reusable by future BRU/LSU dispatchers.

Test Plan:
- ALU_NUM=2, DEPTH=4, issue_valid held high, no pops:
  - Pushes alternate one-hot 01,10,01,10... starting 1 cycle after the first accept.
  - After 8 accepts both occ=4 and issue_ready=0.
- Both full, pop[1] pulsed once: next cycle occ[1]=3, ready=1. The next accept goes to unit 1 regardless of rr_ptr; occ[1] returns to 4.
- occ[0]=4 and occ[1]=2, rr_ptr=0: accept selects unit 1 (full unit skipped); rr_ptr becomes 0.
- Same-cycle accept to unit 0 with pop[0]=1 at occ[0]=3: occ[0] stays 3, push[0] is asserted the next cycle.
- Accept at cycle N, then flush at cycle N+1 with issue_valid high:
  - No accept in cycle N+1.
  - push=0 at N+2 (the N+1 push is already out and cleared by the FIFO's own flush).
  - All occ=0 at N+2; rr_ptr is preserved.
- pop[0]=1 with occ[0]=0 -> credit_error=1 and stays 1. Then rst=0 for 1 cycle -> credit_error=0, occ=0, push=0.

Source files
------------

// File: rtl/execute_alu_dispatcher_pkg.sv
// Shared types and defaults for the execute-stage ALU dispatcher slice.
// Holds the issue/commit packet layouts and the default ALU unit count and FIFO depth.
package execute_alu_dispatcher_pkg;

  localparam int ALU_UNIT_NUM   = 2;
  localparam int ALU_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic        exception;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [15:0] pc;
  } issue_execute_pack_t;

  typedef struct packed {
    logic        enable;
    logic        flush;
    logic [15:0] redirect_pc;
  } commit_feedback_pack_t;

  // Increment modulo n without needing n to be a power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/execute_alu_dispatcher_rr_free_select.sv
// Round-robin first-free picker: starting at 'start', returns the first set bit of 'free'.
// Kept generic so other dispatchers (BRU/LSU) can reuse it.
module rr_free_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     free,
  output logic [N-1:0]     sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             any
);

  // Scan from the far end backwards so the last hit written is the nearest to start.
  always_comb begin
    int idx;
    idx        = 0;
    sel_idx    = '0;
    any        = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (free[idx]) begin
        sel_idx = IDX_W'(idx);
        any     = 1'b1;
      end
    end
    sel_onehot = any ? (N'(1) << sel_idx) : '0;
  end

endmodule

// File: rtl/execute_alu_dispatcher.sv
// Routes one issued instruction per cycle round-robin to ALU FIFOs with free credit.
// Credits are taken at accept time and returned by each unit's pop strobe.
module execute_alu_dispatcher
  import execute_alu_dispatcher_pkg::*;
#(
  parameter int ALU_NUM    = ALU_UNIT_NUM,
  parameter int FIFO_DEPTH = ALU_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  issue_execute_pack_t        issue_data,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  output issue_execute_pack_t        alu_fifo_data_in,
  output logic [ALU_NUM-1:0]         alu_fifo_push,
  input  logic [ALU_NUM-1:0]         alu_fifo_pop,
  output logic [ALU_NUM*CNT_W-1:0]   alu_fifo_occupancy,
  input  commit_feedback_pack_t      commit_feedback_pack,
  output logic                       credit_error
);

  localparam int IDX_W = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;

  logic [CNT_W-1:0]   occ_reg [ALU_NUM];
  logic [ALU_NUM-1:0] free_vec;
  logic [ALU_NUM-1:0] sel_onehot;
  logic [ALU_NUM-1:0] credit_err_vec;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_free;
  logic               flush;
  logic               accept;

  assign flush = commit_feedback_pack.enable && commit_feedback_pack.flush;

  rr_free_select #(
    .N     (ALU_NUM),
    .IDX_W (IDX_W)
  ) u_rr_free_select (
    .start      (rr_ptr_reg),
    .free       (free_vec),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .any        (any_free)
  );

  assign issue_ready = any_free && !flush;
  assign accept      = issue_valid && issue_ready;
  assign rr_ptr_next = IDX_W'(wrap_inc(int'(sel_idx), ALU_NUM));

  generate
    for (genvar gi = 0; gi < ALU_NUM; gi++) begin : g_unit
      logic inc;
      logic dec;

      assign inc = accept && sel_onehot[gi];
      // The FIFOs clear themselves on flush, so a pop in that cycle carries no credit.
      assign dec = alu_fifo_pop[gi] && !flush;

      assign free_vec[gi] = occ_reg[gi] < CNT_W'(FIFO_DEPTH);
      assign credit_err_vec[gi] = (dec && !inc && occ_reg[gi] == '0) ||
                                  (inc && !dec && occ_reg[gi] == CNT_W'(FIFO_DEPTH));
      assign alu_fifo_occupancy[gi*CNT_W +: CNT_W] = occ_reg[gi];

      always_ff @(posedge clk) begin
        if (!rst) begin
          occ_reg[gi] <= '0;
        end else if (flush) begin
          occ_reg[gi] <= '0;
        end else if (inc && !dec) begin
          occ_reg[gi] <= occ_reg[gi] + 1'b1;
        end else if (dec && !inc && occ_reg[gi] != '0) begin
          occ_reg[gi] <= occ_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

  // A flush forces issue_ready low, so no accept means the pending push is dropped too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_fifo_push    <= '0;
      alu_fifo_data_in <= '0;
      rr_ptr_reg       <= '0;
      credit_error     <= 1'b0;
    end else begin
      alu_fifo_push <= accept ? sel_onehot : '0;
      if (accept) begin
        alu_fifo_data_in <= issue_data;
        rr_ptr_reg       <= rr_ptr_next;
      end
      if (|credit_err_vec) credit_error <= 1'b1;
    end
  end

endmodule
